uart_rx_cfg: RTL
================

Name: uart_rx_cfg

Overview:
Second-generation UART receiver for the low-power processing system, replacing the fixed 8-bit receive path on the serial register-file link. It adds the following over the previous receiver:
- parametrised data width;
- runtime-configurable prescale (oversampling ratio);
- optional second stop bit;
- majority-of-3 bit sampling;
- input synchroniser;
- separate error pulses;
- per-frame configuration capture.
It sits between the RX pad and the RX-side clock-domain synchroniser / system controller.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal 5..9.
SYNC_STAGES, 2, flops in the RX_IN synchroniser; legal 2..3.
PRESCALE_W, 6, width of the Prescale port and edge counter.

Ports:
CLK  in  1  receiver clock (oversampling clock).
RST  in  1  synchronous, active-high reset.
RX_IN  in  1  serial line; idle high.
PAR_EN  in  1  1 = parity bit present.
PAR_TYP  in  1  0 = even, 1 = odd.
STOP2  in  1  1 = two stop bits.
Prescale  in  PRESCALE_W  clocks per bit.
P_DATA  out  DATA_WIDTH  received word, LSB first on the line.
DATA_VALID  out  1  one-cycle pulse: P_DATA updated with a good frame.
PAR_ERR  out  1  one-cycle pulse: parity mismatch.
STP_ERR  out  1  one-cycle pulse: a stop bit was sampled 0.
BUSY  out  1  high whenever state != IDLE.

Behaviour:
- Clocking and reset: one clock, CLK. Reset is synchronous and active-high on RST.
- Reset values:
  - P_DATA = 0; DATA_VALID, PAR_ERR, STP_ERR, BUSY = 0.
  - State = IDLE; counters = 0.
  - Synchroniser flops = 1.
  - Reset mid-frame aborts the frame: no pulses, BUSY = 0 on the cycle after RST.
- Input synchroniser: all decisions use rx_s, the output of the SYNC_STAGES synchroniser.
- Configuration capture: PAR_EN, PAR_TYP, STOP2 and Prescale are captured on IDLE->START. Changes during a frame take effect on the next frame only.
- Prescale rules:
  - Bit 0 is ignored (value forced even).
  - Values below 8 are treated as 8.
  - Supported range: 8..(2^PRESCALE_W - 2).
- Counters:
  - edge_cnt runs 0..P-1 within each bit and wraps at P-1, advancing bit_cnt.
  - mid = P/2.
- Sampling:
  - rx_s is sampled at edge_cnt = mid-1, mid and mid+1.
  - The bit value is the majority of the three samples, decided at edge mid+1.
  - Any action resulting from that decision is registered on the same clock edge.
- States:
  - IDLE: rx_s = 0 -> START, with edge_cnt = 0 and bit_cnt = 0 on entry.
  - START:
    - Majority = 1 at mid+1 (glitch) -> IDLE, no pulses.
    - Otherwise, at edge P-1 -> DATA.
  - DATA:
    - DATA_WIDTH bits are shifted into a holding register, LSB first.
    - After the last bit wraps -> PARITY if PAR_EN, else STOP.
    - The parity accumulator XORs the data bits.
  - PARITY:
    - Expected parity bit = XOR(data) ^ PAR_TYP.
    - The mismatch is recorded at mid+1.
    - At edge P-1 -> STOP.
  - STOP:
    - Each stop bit is sampled by majority. With STOP2, the first stop bit is checked, wraps at P-1, then the second is checked.
    - Action at mid+1 of the last stop bit:
      - No errors: DATA_VALID = 1 and P_DATA <= holding register; -> IDLE.
      - Parity mismatch, stop bits good: PAR_ERR = 1; -> IDLE.
      - Any stop bit = 0: STP_ERR = 1 (plus PAR_ERR if parity also mismatched); -> WAIT_IDLE.
    - On any error, DATA_VALID = 0 and P_DATA holds its previous value.
    - The first-stop-bit error is remembered when STOP2 = 1.
  - WAIT_IDLE: stays (BUSY = 1) until rx_s = 1, then -> IDLE. This covers the break condition: no false start bits are generated while the line is held low.
- Pulse timing:
  - Pulses are high for exactly one cycle and are mutually exclusive with DATA_VALID.
  - The early return to IDLE at mid+1 of the last stop bit allows back-to-back frames with no idle gap.
- Latency: from entry into START, DATA_VALID rises after F*P + mid + 2 clocks, where F = 1 + DATA_WIDTH + PAR_EN + STOP2 (the index of the last stop bit).

Test Plan:
1. DATA_WIDTH = 8, P = 16, 8N1, frame 0xA5 -> single DATA_VALID pulse 154 clocks after START entry; P_DATA = 0xA5; PAR_ERR = STP_ERR = 0; BUSY drops the next cycle.
2. 8E1, data 0x3C sent with parity bit 1 (wrong) -> PAR_ERR pulse; DATA_VALID = 0; P_DATA stays 0xA5. Then a correct 8O1 frame 0x3C -> DATA_VALID with P_DATA = 0x3C.
3. 8N2, data 0x5A, second stop bit 0 then line held low 100 clocks -> STP_ERR pulse; BUSY stays 1 until the line goes high; no new frame starts. Next frame 0x5A -> DATA_VALID, P_DATA = 0x5A.
4. RX_IN low for 6 clocks (P = 16) -> no pulses; BUSY returns to 0 at edge mid+2. A following valid frame 0x11 decodes correctly.
5. Majority filter: frame 0xC3 with a one-clock inversion at edge mid of every bit -> P_DATA = 0xC3, no errors. Inversion spanning edges mid-1 and mid of bit 3 -> bit 3 flipped (P_DATA = 0xCB).
6. Prescale changed 16->8 mid-frame -> the current frame still decodes at 16 (0x96 valid); the next frame at 8 decodes 0x69. RST asserted during DATA of a third frame -> no pulses, all outputs 0 next cycle.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchronised input, majority-of-3 bit sampling,
// per-frame capture of parity/stop/prescale settings and separate error pulses.
module uart_rx_cfg #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int PRESCALE_W  = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic                  BUSY
);

  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [PRESCALE_W-1:0] P_ONE = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] P_MIN = PRESCALE_W'(8);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_e;

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic [PRESCALE_W-1:0]   presc_q, presc_d;
  logic                    par_en_q, par_en_d;
  logic                    par_typ_q, par_typ_d;
  logic                    stop2_q, stop2_d;
  logic [PRESCALE_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [1:0]              samp_q, samp_d;
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;
  logic                    par_acc_q, par_acc_d;
  logic                    par_bad_q, par_bad_d;
  logic                    stp_bad_q, stp_bad_d;
  logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
  logic                    valid_q, valid_d;
  logic                    par_err_q, par_err_d;
  logic                    stp_err_q, stp_err_d;

  logic                    rx_s;
  logic [PRESCALE_W-1:0]   presc_in;
  logic [PRESCALE_W-1:0]   mid;
  logic                    at_lo, at_mid, at_dec, at_end;
  logic                    maj;
  logic                    stop_fail;

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Prescale is forced even and clamped to a minimum of 8 before capture.
  always_comb begin
    presc_in = Prescale & ~P_ONE;
    if (presc_in < P_MIN) presc_in = P_MIN;
  end

  assign mid       = presc_q >> 1;
  assign at_lo     = (edge_cnt_q == mid - P_ONE);
  assign at_mid    = (edge_cnt_q == mid);
  assign at_dec    = (edge_cnt_q == mid + P_ONE);
  assign at_end    = (edge_cnt_q == presc_q - P_ONE);
  assign maj       = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
  assign stop_fail = stp_bad_q | ~maj;

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], RX_IN};
    state_d    = state_q;
    presc_d    = presc_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    stop2_d    = stop2_q;
    edge_cnt_d = '0;
    bit_cnt_d  = bit_cnt_q;
    samp_d     = samp_q;
    hold_d     = hold_q;
    par_acc_d  = par_acc_q;
    par_bad_d  = par_bad_q;
    stp_bad_d  = stp_bad_q;
    p_data_d   = p_data_q;
    valid_d    = 1'b0;
    par_err_d  = 1'b0;
    stp_err_d  = 1'b0;

    if (state_q inside {S_START, S_DATA, S_PARITY, S_STOP}) begin
      edge_cnt_d = at_end ? '0 : edge_cnt_q + P_ONE;
      if (at_lo)  samp_d[0] = rx_s;
      if (at_mid) samp_d[1] = rx_s;
    end

    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        if (!rx_s) begin
          state_d   = S_START;
          presc_d   = presc_in;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          stop2_d   = STOP2;
          par_acc_d = 1'b0;
          par_bad_d = 1'b0;
          stp_bad_d = 1'b0;
        end
      end
      S_START: begin
        if (at_dec && maj) begin
          state_d    = S_IDLE;
          edge_cnt_d = '0;
        end else if (at_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (at_dec) begin
          hold_d    = {maj, hold_q[DATA_WIDTH-1:1]};
          par_acc_d = par_acc_q ^ maj;
        end
        if (at_end) begin
          if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (at_dec) par_bad_d = (maj != (par_acc_q ^ par_typ_q));
        if (at_end) state_d = S_STOP;
      end
      S_STOP: begin
        // Leaving at mid+1 of the last stop bit lets the next start bit follow with no gap.
        if (at_dec) begin
          if (stop2_q && (bit_cnt_q == '0)) begin
            stp_bad_d = stp_bad_q | ~maj;
          end else begin
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
            if (stop_fail) begin
              stp_err_d = 1'b1;
              par_err_d = par_bad_q;
              state_d   = S_WAIT_IDLE;
            end else if (par_bad_q) begin
              par_err_d = 1'b1;
              state_d   = S_IDLE;
            end else begin
              valid_d  = 1'b1;
              p_data_d = hold_q;
              state_d  = S_IDLE;
            end
          end
        end else if (at_end) begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
      S_WAIT_IDLE: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      sync_q     <= '1;
      presc_q    <= P_MIN;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      stop2_q    <= 1'b0;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      samp_q     <= '0;
      hold_q     <= '0;
      par_acc_q  <= 1'b0;
      par_bad_q  <= 1'b0;
      stp_bad_q  <= 1'b0;
      p_data_q   <= '0;
      valid_q    <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      presc_q    <= presc_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      stop2_q    <= stop2_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      samp_q     <= samp_d;
      hold_q     <= hold_d;
      par_acc_q  <= par_acc_d;
      par_bad_q  <= par_bad_d;
      stp_bad_q  <= stp_bad_d;
      p_data_q   <= p_data_d;
      valid_q    <= valid_d;
      par_err_q  <= par_err_d;
      stp_err_q  <= stp_err_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign DATA_VALID = valid_q;
  assign PAR_ERR    = par_err_q;
  assign STP_ERR    = stp_err_q;
  assign BUSY       = (state_q != S_IDLE);

endmodule
